// File: rtl/hierarquia_pkg.sv
// rtl/hierarquia_pkg.sv - shared widths, FSM encoding and line field layout for the cache controller
// Purpose: one place for the default ADDR_W/DATA_W/LINES, the controller state encoding
// and the bit positions of the valid/dirty/lru/tag/data fields inside a stored line word.
// Line word layout (MSB..LSB): valid | dirty | lru | tag[ADDR_W] | data[DATA_W]
package hierarquia_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LINES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_RESPOND   = 3'd4
  } state_e;

  function automatic int line_data_lsb(input int dw);
    return dw - dw;
  endfunction

  function automatic int line_tag_lsb(input int dw);
    return dw;
  endfunction

  function automatic int line_lru_bit(input int aw, input int dw);
    return dw + aw;
  endfunction

  function automatic int line_dirty_bit(input int aw, input int dw);
    return dw + aw + 1;
  endfunction

  function automatic int line_valid_bit(input int aw, input int dw);
    return dw + aw + 2;
  endfunction

  function automatic int line_width(input int aw, input int dw);
    return dw + aw + 3;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - fully associative line storage with parallel tag compare
// Purpose: holds LINES line words, reports hit/hit index for lookup_addr_i, picks the
// miss victim (lowest invalid line, else lowest line with lru=0) and exposes one read port.
// Ports: clock/resetn; lookup_addr_i -> hit_o, hit_idx_o, victim_idx_o;
//        rd_idx_i -> rd_valid_o, rd_dirty_o, rd_tag_o, rd_data_o;
//        wr_en_i/wr_idx_i/wr_dirty_i/wr_tag_i/wr_data_i install or update a line (valid=1);
//        clr_dirty_en_i clears dirty of line wr_idx_i; touch_en_i/touch_idx_i update lru.
module cache_line_array
  import hierarquia_pkg::*;
#(
  parameter int ADDR_W = hierarquia_pkg::ADDR_W,
  parameter int DATA_W = hierarquia_pkg::DATA_W,
  parameter int LINES  = hierarquia_pkg::LINES,
  parameter int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  hit_idx_o,
  output logic [IDX_W-1:0]  victim_idx_o,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [ADDR_W-1:0] rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_dirty_i,
  input  logic [ADDR_W-1:0] wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_dirty_en_i,
  input  logic              touch_en_i,
  input  logic [IDX_W-1:0]  touch_idx_i
);

  localparam int DATA_LSB  = line_data_lsb(DATA_W);
  localparam int TAG_LSB   = line_tag_lsb(DATA_W);
  localparam int LRU_BIT   = line_lru_bit(ADDR_W, DATA_W);
  localparam int DIRTY_BIT = line_dirty_bit(ADDR_W, DATA_W);
  localparam int VALID_BIT = line_valid_bit(ADDR_W, DATA_W);
  localparam int LINE_W    = line_width(ADDR_W, DATA_W);

  logic [LINE_W-1:0] line_q [LINES];

  logic             inv_found;
  logic             lru_found;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] lru_idx;

  // Parallel compare; the first matching / first candidate line wins.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    lru_found = 1'b0;
    lru_idx   = '0;
    for (int i = 0; i < LINES; i++) begin
      if (!hit_o && line_q[i][VALID_BIT] && (line_q[i][TAG_LSB +: ADDR_W] == lookup_addr_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
      if (!inv_found && !line_q[i][VALID_BIT]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
      if (!lru_found && !line_q[i][LRU_BIT]) begin
        lru_found = 1'b1;
        lru_idx   = IDX_W'(i);
      end
    end
    victim_idx_o = inv_found ? inv_idx : lru_idx;
  end

  assign rd_valid_o = line_q[rd_idx_i][VALID_BIT];
  assign rd_dirty_o = line_q[rd_idx_i][DIRTY_BIT];
  assign rd_tag_o   = line_q[rd_idx_i][TAG_LSB +: ADDR_W];
  assign rd_data_o  = line_q[rd_idx_i][DATA_LSB +: DATA_W];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LINES; i++) begin
        line_q[i]          <= '0;
        line_q[i][LRU_BIT] <= (i == 1);
      end
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (clr_dirty_en_i && (wr_idx_i == IDX_W'(i))) begin
          line_q[i][DIRTY_BIT] <= 1'b0;
        end
        if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          line_q[i][VALID_BIT]             <= 1'b1;
          line_q[i][DIRTY_BIT]             <= wr_dirty_i;
          line_q[i][TAG_LSB +: ADDR_W]     <= wr_tag_i;
          line_q[i][DATA_LSB +: DATA_W]    <= wr_data_i;
        end
        if (touch_en_i) begin
          line_q[i][LRU_BIT] <= (touch_idx_i == IDX_W'(i));
        end
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-back, write-allocate cache controller FSM
// Purpose: serves single-word CPU reads/writes from a small fully associative cache,
// writing back dirty victims and filling misses over a req/ack RAM port.
// Ports: clock/resetn; CPU side cpu_req/cpu_write/cpu_addr/cpu_wdata in,
//        cpu_ready/cpu_done/cpu_rdata/hit out; RAM side mem_req/mem_write/mem_addr/
//        mem_wdata out, mem_rdata/mem_ack in; state = current FSM state for debug LEDs.
module cache_controller
  import hierarquia_pkg::*;
#(
  parameter int ADDR_W = hierarquia_pkg::ADDR_W,
  parameter int DATA_W = hierarquia_pkg::DATA_W,
  parameter int LINES  = hierarquia_pkg::LINES
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        state
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  vic_q, vic_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d;
  // Forces one low mem_req cycle between the write-back and the following fill.
  logic              gap_q, gap_d;

  logic              arr_hit;
  logic [IDX_W-1:0]  arr_hit_idx;
  logic [IDX_W-1:0]  arr_victim_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic              rd_dirty;
  logic [ADDR_W-1:0] rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_dirty;
  logic [DATA_W-1:0] wr_data;
  logic              clr_dirty_en;
  logic              touch_en;
  logic [IDX_W-1:0]  touch_idx;
  logic              ack_seen;

  cache_line_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_lines (
    .clock         (clock),
    .resetn        (resetn),
    .lookup_addr_i (addr_q),
    .hit_o         (arr_hit),
    .hit_idx_o     (arr_hit_idx),
    .victim_idx_o  (arr_victim_idx),
    .rd_idx_i      (rd_idx),
    .rd_valid_o    (rd_valid),
    .rd_dirty_o    (rd_dirty),
    .rd_tag_o      (rd_tag),
    .rd_data_o     (rd_data),
    .wr_en_i       (wr_en),
    .wr_idx_i      (wr_idx),
    .wr_dirty_i    (wr_dirty),
    .wr_tag_i      (addr_q),
    .wr_data_i     (wr_data),
    .clr_dirty_en_i(clr_dirty_en),
    .touch_en_i    (touch_en),
    .touch_idx_i   (touch_idx)
  );

  // During LOOKUP the read port looks at the hit line or the candidate victim;
  // afterwards it stays on the latched victim so write-back data is stable.
  assign rd_idx = (state_q == ST_LOOKUP) ? (arr_hit ? arr_hit_idx : arr_victim_idx) : vic_q;

  // RAM-side outputs decode straight from registered state, so an asynchronous
  // reset drops mem_req immediately.
  assign mem_req   = (state_q == ST_WRITEBACK) || ((state_q == ST_FILL) && !gap_q);
  assign mem_write = (state_q == ST_WRITEBACK);
  assign mem_addr  = (state_q == ST_WRITEBACK) ? rd_tag :
                     (state_q == ST_FILL)      ? addr_q : '0;
  assign mem_wdata = (state_q == ST_WRITEBACK) ? rd_data : '0;
  assign ack_seen  = mem_req && mem_ack;

  assign cpu_ready = (state_q == ST_IDLE);
  assign cpu_done  = (state_q == ST_RESPOND);
  assign cpu_rdata = cpu_done ? rdata_q : '0;
  assign hit       = cpu_done && hit_q;
  assign state     = state_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    vic_d        = vic_q;
    rdata_d      = rdata_q;
    hit_d        = hit_q;
    gap_d        = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = vic_q;
    wr_dirty     = 1'b0;
    wr_data      = wdata_q;
    clr_dirty_en = 1'b0;
    touch_en     = 1'b0;
    touch_idx    = vic_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          write_d = cpu_write;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (arr_hit) begin
          hit_d     = 1'b1;
          touch_en  = 1'b1;
          touch_idx = arr_hit_idx;
          state_d   = ST_RESPOND;
          if (write_q) begin
            wr_en    = 1'b1;
            wr_idx   = arr_hit_idx;
            wr_dirty = 1'b1;
            rdata_d  = wdata_q;
          end else begin
            rdata_d  = rd_data;
          end
        end else begin
          vic_d = arr_victim_idx;
          hit_d = 1'b0;
          if (rd_valid && rd_dirty) begin
            state_d = ST_WRITEBACK;
          end else if (write_q) begin
            wr_en     = 1'b1;
            wr_idx    = arr_victim_idx;
            wr_dirty  = 1'b1;
            touch_en  = 1'b1;
            touch_idx = arr_victim_idx;
            rdata_d   = wdata_q;
            state_d   = ST_RESPOND;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_WRITEBACK: begin
        if (ack_seen) begin
          if (write_q) begin
            // Installing over the victim also replaces its dirty bit.
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            touch_en = 1'b1;
            rdata_d  = wdata_q;
            state_d  = ST_RESPOND;
          end else begin
            clr_dirty_en = 1'b1;
            gap_d        = 1'b1;
            state_d      = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (ack_seen) begin
          wr_en    = 1'b1;
          wr_data  = mem_rdata;
          touch_en = 1'b1;
          rdata_d  = mem_rdata;
          hit_d    = 1'b0;
          state_d  = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      vic_q   <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      vic_q   <= vic_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      gap_q   <= gap_d;
    end
  end

endmodule
